// File: rtl/sd_card_responder.sv
// Card-side responder for the single-line SD command/data exchange.
// Captures the 48-bit host command shifted in on d1_in (LSB first), then
// returns R1, an optional zero gap, the 0xFE start token, a turnaround bit
// and one 32-bit data word on d0_out.
//
// The frame position is carried entirely by cnt, which tracks the host's
// cycle counter. Every phase, pulse and D0 bit is decoded from cnt and
// latched registers only. The D0 path therefore never sees d1_in or the
// live resp/data inputs combinationally.
module sd_card_responder #(
  parameter int GAP_BITS = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        d1_in,
  output logic        d0_out,
  output logic        d0_oe,
  input  logic [7:0]  resp_r1,
  input  logic [31:0] data_word,
  input  logic        data_en,
  output logic [7:0]  cmd_number,
  output logic [31:0] cmd_args,
  output logic [7:0]  cmd_crc,
  output logic        cmd_valid,
  output logic        frame_done
);

  typedef enum logic [3:0] {
    IDLE, CMD, DUMMY, RESP, GAP, TOKEN, TURN, DATA, DONE
  } phase_t;

  localparam logic [10:0] T0          = 11'(64 + GAP_BITS);
  localparam logic [10:0] TURN_CNT    = T0 + 11'd8;
  localparam logic [10:0] DATA_FIRST  = T0 + 11'd9;
  localparam logic [10:0] DATA_LAST   = T0 + 11'd40;
  localparam logic [7:0]  START_TOKEN = 8'hFE;

  logic [10:0] cnt;
  logic [10:0] cnt_next;
  phase_t      phase;
  logic [47:0] shift_q;
  logic [47:0] shift_next;
  logic [7:0]  r1_q;
  logic [31:0] data_q;
  logic        data_en_q;
  logic [2:0]  tok_idx;
  logic [4:0]  data_idx;

  // Frame counter: this is the state register; the phase is decoded from it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt_next;
  end

  // Next count (clear when idle, saturate at the top), phase decode and
  // the command shift value.
  always_comb begin
    cnt_next   = '0;
    shift_next = {d1_in, shift_q[47:1]};
    if (enable) cnt_next = (cnt == 11'h7FF) ? cnt : cnt + 11'd1;
    phase = DONE;
    if (cnt == 11'd0 && !enable) phase = IDLE;
    else if (cnt < 11'd48)       phase = CMD;
    else if (cnt < 11'd56)       phase = DUMMY;
    else if (cnt < 11'd64)       phase = RESP;
    else if (!data_en_q)         phase = DONE;
    else if (cnt < T0)           phase = GAP;
    else if (cnt < TURN_CNT)     phase = TOKEN;
    else if (cnt == TURN_CNT)    phase = TURN;
    else if (cnt <= DATA_LAST)   phase = DATA;
    else                         phase = DONE;
  end

  // D0 drive: released lines read as 1; token goes MSB first, R1 and data LSB first.
  always_comb begin
    d0_oe    = 1'b0;
    d0_out   = 1'b1;
    tok_idx  = 3'(cnt - T0);
    data_idx = 5'(cnt - DATA_FIRST);
    case (phase)
      RESP: begin
        d0_oe  = 1'b1;
        d0_out = r1_q[cnt[2:0]];
      end
      GAP: begin
        d0_oe  = 1'b1;
        d0_out = 1'b0;
      end
      TOKEN: begin
        d0_oe  = 1'b1;
        d0_out = START_TOKEN[~tok_idx];
      end
      TURN: begin
        d0_oe  = 1'b1;
        d0_out = 1'b1;
      end
      DATA: begin
        d0_oe  = 1'b1;
        d0_out = data_q[data_idx];
      end
      default: begin
        d0_oe  = 1'b0;
        d0_out = 1'b1;
      end
    endcase
  end

  // Pulses exist only when cnt actually reaches them, so an aborted frame never fires one.
  assign cmd_valid  = (cnt == 11'd48);
  assign frame_done = data_en_q ? (cnt == DATA_LAST) : (cnt == 11'd64);

  // Command capture and response latching. The published cmd_* change only
  // when a full 48 bits have arrived; the response is sampled at the end of DUMMY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q    <= '0;
      cmd_number <= '0;
      cmd_args   <= '0;
      cmd_crc    <= '0;
      r1_q       <= '0;
      data_q     <= '0;
      data_en_q  <= 1'b0;
    end else if (enable) begin
      if (cnt < 11'd48) shift_q <= shift_next;
      if (cnt == 11'd47) {cmd_crc, cmd_args, cmd_number} <= shift_next;
      if (cnt == 11'd55) begin
        r1_q      <= resp_r1;
        data_q    <= data_word;
        data_en_q <= data_en;
      end
    end
  end

endmodule

// File: tb/tb_sd_card_responder.sv
// Bench for sd_card_responder: one instance with no gap and one with a
// four-bit gap, both driven by the same host-side frames. Expected command
// captures, D0 bit streams and frame_done positions are queued when a frame
// starts; a monitor on the falling edge pops and compares whatever the DUTs present.
module tb_sd_card_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        d1_in = 1'b0;
  logic [7:0]  resp_r1 = '0;
  logic [31:0] data_word = '0;
  logic        data_en = 1'b0;

  logic        d0_out, d0_oe, cmd_valid, frame_done;
  logic [7:0]  cmd_number, cmd_crc;
  logic [31:0] cmd_args;
  logic        g_d0_out, g_d0_oe, g_cmd_valid, g_frame_done;
  logic [7:0]  g_cmd_number, g_cmd_crc;
  logic [31:0] g_cmd_args;

  int n_checks = 0;
  int n_errors = 0;
  int cur_k = -1;

  logic [47:0] exp_q[$];
  logic [0:0]  exp_d0_q[$];
  logic [0:0]  exp_g_d0_q[$];
  int          exp_fd_q[$];
  int          exp_g_fd_q[$];

  sd_card_responder #(.GAP_BITS(0)) dut (
    .clk(clk), .reset(reset), .enable(enable), .d1_in(d1_in),
    .d0_out(d0_out), .d0_oe(d0_oe), .resp_r1(resp_r1), .data_word(data_word),
    .data_en(data_en), .cmd_number(cmd_number), .cmd_args(cmd_args),
    .cmd_crc(cmd_crc), .cmd_valid(cmd_valid), .frame_done(frame_done)
  );

  sd_card_responder #(.GAP_BITS(4)) dut_g4 (
    .clk(clk), .reset(reset), .enable(enable), .d1_in(d1_in),
    .d0_out(g_d0_out), .d0_oe(g_d0_oe), .resp_r1(resp_r1), .data_word(data_word),
    .data_en(data_en), .cmd_number(g_cmd_number), .cmd_args(g_cmd_args),
    .cmd_crc(g_cmd_crc), .cmd_valid(g_cmd_valid), .frame_done(g_frame_done)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got %h want %h (k=%0d, t=%0t)", name, got, want, cur_k, $time);
    end
  endtask

  // Queue the D0 bits and the frame_done position of one response.
  task automatic push_resp(input logic [7:0] r1, input logic [31:0] data, input logic de,
                           input int gap, input bit to_g);
    logic [7:0] tok;
    tok = 8'hFE;
    for (int i = 0; i < 8; i++)
      if (to_g) exp_g_d0_q.push_back(r1[i]); else exp_d0_q.push_back(r1[i]);
    if (de) begin
      for (int i = 0; i < gap; i++)
        if (to_g) exp_g_d0_q.push_back(1'b0); else exp_d0_q.push_back(1'b0);
      for (int i = 7; i >= 0; i--)
        if (to_g) exp_g_d0_q.push_back(tok[i]); else exp_d0_q.push_back(tok[i]);
      if (to_g) exp_g_d0_q.push_back(1'b1); else exp_d0_q.push_back(1'b1);
      for (int i = 0; i < 32; i++)
        if (to_g) exp_g_d0_q.push_back(data[i]); else exp_d0_q.push_back(data[i]);
    end
    if (to_g) exp_g_fd_q.push_back(de ? 64 + gap + 40 : 64);
    else      exp_fd_q.push_back(de ? 64 + gap + 40 : 64);
  endtask

  // Drive one host frame. stop_at >= 0 aborts (enable low during that cycle)
  // or, with do_reset, asserts reset in the middle of that cycle.
  task automatic run_frame(input logic [7:0] num, input logic [31:0] args, input logic [7:0] crc,
                           input logic [7:0] r1, input logic [31:0] data, input logic de,
                           input int stop_at, input bit do_reset);
    logic [47:0] cmd;
    cmd = {crc, args, num};
    if (stop_at < 0 || (do_reset && stop_at > 48)) exp_q.push_back(cmd);
    if (stop_at < 0 || do_reset) begin
      push_resp(r1, data, de, 0, 1'b0);
      push_resp(r1, data, de, 4, 1'b1);
    end
    resp_r1 = r1; data_word = data; data_en = de;
    for (int k = 0; k < 115; k++) begin
      if (stop_at >= 0 && k == stop_at && !do_reset) break;
      @(posedge clk); #1;
      enable = 1'b1;
      cur_k  = k;
      d1_in  = (k < 48) ? cmd[k] : 1'($urandom_range(0, 1));
      if (k == 56) begin
        resp_r1 = 8'($urandom); data_word = $urandom; data_en = ~de;
      end
      if (do_reset && k == stop_at) begin
        #2 reset = 1'b1;
        #1;
        exp_d0_q.delete(); exp_g_d0_q.delete(); exp_fd_q.delete(); exp_g_fd_q.delete();
        check("rst_mid_d0_oe", d0_oe, 1'b0);
        check("rst_mid_d0_out", d0_out, 1'b1);
        check("rst_mid_cmd", {cmd_crc, cmd_args, cmd_number}, 48'h0);
        check("rst_mid_pulses", {cmd_valid, frame_done}, 2'b00);
        break;
      end
    end
    @(posedge clk); #1;
    enable = 1'b0;
    cur_k  = -1;
    if (do_reset) begin
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("cmd_left", exp_q.size(), 0);
    check("d0_left", exp_d0_q.size(), 0);
    check("g4_d0_left", exp_g_d0_q.size(), 0);
    check("fd_left", exp_fd_q.size(), 0);
    check("g4_fd_left", exp_g_fd_q.size(), 0);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (cmd_valid) begin
      check("cmd_valid_pos", cur_k, 48);
      if (exp_q.size() == 0) check("cmd_unexpected", 1'b1, 1'b0);
      else check("cmd_fields", {cmd_crc, cmd_args, cmd_number}, exp_q.pop_front());
    end
    if (d0_oe) begin
      if (exp_d0_q.size() == 0) check("d0_oe_extra", d0_oe, 1'b0);
      else check("d0_bit", d0_out, exp_d0_q.pop_front());
    end else begin
      check("d0_idle_high", d0_out, 1'b1);
    end
    if (frame_done) begin
      if (exp_fd_q.size() == 0) check("fd_unexpected", 1'b1, 1'b0);
      else check("fd_pos", cur_k, exp_fd_q.pop_front());
    end
    if (g_d0_oe) begin
      if (exp_g_d0_q.size() == 0) check("g4_d0_oe_extra", g_d0_oe, 1'b0);
      else check("g4_d0_bit", g_d0_out, exp_g_d0_q.pop_front());
    end else begin
      check("g4_d0_idle_high", g_d0_out, 1'b1);
    end
    if (g_frame_done) begin
      if (exp_g_fd_q.size() == 0) check("g4_fd_unexpected", 1'b1, 1'b0);
      else check("g4_fd_pos", cur_k, exp_g_fd_q.pop_front());
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    #12;
    check("rst_d0_oe", d0_oe, 1'b0);
    check("rst_d0_out", d0_out, 1'b1);
    check("rst_cmd", {cmd_crc, cmd_args, cmd_number}, 48'h0);
    check("rst_pulses", {cmd_valid, frame_done, g_cmd_valid, g_frame_done}, 4'b0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);

    // Read with data: 0x51 / 0x00001234 / 0xFF, R1 0x00, 0xDEADBEEF
    run_frame(8'h51, 32'h0000_1234, 8'hFF, 8'h00, 32'hDEAD_BEEF, 1'b1, -1, 1'b0);
    check("hold_num_a", cmd_number, 8'h51);
    check("hold_args_a", cmd_args, 32'h0000_1234);
    check("hold_crc_a", cmd_crc, 8'hFF);

    // R1 only
    run_frame(8'h11, 32'hA5A5_0F0F, 8'h3C, 8'h05, 32'hCAFE_F00D, 1'b0, -1, 1'b0);

    // Abort at cnt 30: previous capture must survive
    run_frame(8'h7F, 32'hFFFF_FFFF, 8'h00, 8'hAA, 32'h0, 1'b1, 30, 1'b0);
    check("abort_num", cmd_number, 8'h11);
    check("abort_args", cmd_args, 32'hA5A5_0F0F);
    check("abort_crc", cmd_crc, 8'h3C);
    check("abort_d0_oe", d0_oe, 1'b0);

    // Frame after abort
    run_frame(8'h40, 32'h0000_0000, 8'h95, 8'h01, 32'h1234_5678, 1'b1, -1, 1'b0);

    // Reset in the middle of DATA
    run_frame(8'h52, 32'h0000_0200, 8'h6B, 8'h00, 32'h5555_AAAA, 1'b1, 80, 1'b1);
    check("post_rst_num", cmd_number, 8'h00);

    // Frame after reset
    run_frame(8'h58, 32'h8000_0001, 8'h81, 8'h80, 32'h8000_0001, 1'b1, -1, 1'b0);
    check("final_args", cmd_args, 32'h8000_0001);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
